// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream, framing bursts of BURST_LEN beats
// with tlast; short bursts are closed by an idle timeout or a flush pulse.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  input  logic                  fifo_is_empty,
  input  logic [ADDR_WIDTH:0]   fifo_data_avail,
  input  logic                  flush,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for a full burst, timeout or flush
  // ARM   | latch burst size from FIFO occupancy
  // READ  | popping words into the output buffer
  // DRAIN | all words popped, emptying the buffer up to tlast
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] BURST = CW'(BURST_LEN);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [7:0]    TMO   = 8'(TIMEOUT);

  logic [1:0]            state, state_nxt;
  logic [7:0]            wait_cnt;
  logic                  flush_pend;
  logic [CW-1:0]         rd_left, tx_left, tgt;
  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic                  busy_q;
  logic                  xfer, last_xfer, pop, start;

  assign m_tvalid  = (buf_cnt != 2'd0);
  assign m_tdata   = buf0;
  assign m_tlast   = m_tvalid && (tx_left == ONE);
  assign xfer      = m_tvalid && m_tready;
  assign last_xfer = xfer && m_tlast;
  assign busy      = busy_q;
  assign tgt       = (fifo_data_avail < BURST) ? fifo_data_avail : BURST;
  assign start     = (fifo_data_avail >= BURST) || (wait_cnt == TMO) || flush || flush_pend;

  // The beat leaving this cycle frees a slot, which keeps throughput at one beat per cycle.
  assign pop = (state == READ) && (rd_left != '0) && !fifo_is_empty &&
               (({1'b0, buf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, xfer}));
  assign fifo_r_en = pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     state_nxt = (tgt == '0) ? IDLE : READ;
      READ:    if (pop && rd_left == ONE) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      wait_cnt   <= 8'd0;
      flush_pend <= 1'b0;
      rd_left    <= '0;
      tx_left    <= '0;
      inflight   <= 1'b0;
      buf_cnt    <= 2'd0;
      buf0       <= '0;
      buf1       <= '0;
    end else begin
      state    <= state_nxt;
      busy_q   <= (state_nxt != IDLE);
      inflight <= pop;

      if (state != IDLE || state_nxt != IDLE || fifo_is_empty) wait_cnt <= 8'd0;
      else if (wait_cnt < TMO) wait_cnt <= wait_cnt + 8'd1;

      // A pending flush is consumed by the burst armed now; later pulses queue a new one.
      if (flush && state != IDLE) flush_pend <= 1'b1;
      else if (state == ARM)      flush_pend <= 1'b0;

      if (state == ARM) begin
        rd_left <= tgt;
        tx_left <= tgt;
      end else begin
        if (pop)  rd_left <= rd_left - ONE;
        if (xfer) tx_left <= tx_left - ONE;
      end

      case ({inflight, xfer})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= fifo_r_data;
          else                 buf1 <= fifo_r_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) buf0 <= fifo_r_data;
          else begin
            buf0 <= buf1;
            buf1 <= fifo_r_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model on its read side.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BL = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_is_empty;
  logic [AW:0]   fifo_data_avail;
  logic          flush = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          busy;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fifo_r_en(fifo_r_en), .fifo_r_data(fifo_r_data),
    .fifo_is_empty(fifo_is_empty), .fifo_data_avail(fifo_data_avail), .flush(flush),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .busy(busy)
  );

  // FIFO model: empty flag follows the new pointers, occupancy lags by one cycle
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          hold_empty = 1'b0;
  logic [DW-1:0] mem [16];
  logic [AW:0]   wp, rp, avail_q;
  logic          empty_q;
  logic [DW-1:0] rdata_q;
  logic [AW:0]   wp_n, rp_n;

  assign wp_n            = wp + (AW+1)'(wr_en);
  assign rp_n            = rp + (AW+1)'(fifo_r_en);
  assign fifo_is_empty   = empty_q | hold_empty;
  assign fifo_data_avail = avail_q;
  assign fifo_r_data     = rdata_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0; rp <= '0; avail_q <= '0; empty_q <= 1'b1; rdata_q <= '0;
    end else begin
      if (wr_en) mem[wp[AW-1:0]] <= wr_data;
      if (fifo_r_en) rdata_q <= mem[rp[AW-1:0]];
      wp      <= wp_n;
      rp      <= rp_n;
      empty_q <= (wp_n == rp_n);
      avail_q <= wp - rp;
    end
  end

  int            pops = 0, empty_pop_err = 0, ahead_err = 0, stall_err = 0, outst = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [DW:0]   beat_q [$];

  always @(negedge clk) begin
    if (rst) begin
      outst      <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (fifo_r_en) pops <= pops + 1;
      if (fifo_r_en && fifo_is_empty) empty_pop_err <= empty_pop_err + 1;
      if (m_tvalid && m_tready) beat_q.push_back({m_tlast, m_tdata});
      if (outst + int'(fifo_r_en) - int'(m_tvalid && m_tready) > 2) ahead_err <= ahead_err + 1;
      outst <= outst + int'(fifo_r_en) - int'(m_tvalid && m_tready);
      if (prev_stall && (!m_tvalid || m_tdata != prev_data || m_tlast != prev_last))
        stall_err <= stall_err + 1;
      prev_stall <= m_tvalid && !m_tready;
      prev_data  <= m_tdata;
      prev_last  <= m_tlast;
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_burst(input string tag, input int base, input logic [DW-1:0] first,
                             input int len);
    logic [DW:0]   b;
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      b = (base + i < beat_q.size()) ? beat_q[base + i] : {1'b0, {DW{1'b1}}};
      d = first + DW'(i);
      check($sformatf("%s_data%0d", tag, i), 32'(b[DW-1:0]), 32'(d));
      check($sformatf("%s_last%0d", tag, i), 32'(b[DW]), 32'(i == len - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, p0, n, b1;
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    run(3);
    check("rst_r_en",   32'(fifo_r_en), 0);
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tlast",  32'(m_tlast), 0);
    check("rst_tdata",  32'(m_tdata), 0);
    check("rst_busy",   32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // two full bursts
    base = beat_q.size(); p0 = pops;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    run(40);
    check("full_beats", 32'(beat_q.size() - base), 8);
    check_burst("full_a", base, 8'h10, 4);
    check_burst("full_b", base + 4, 8'h14, 4);
    check("full_pops", 32'(pops - p0), 8);
    check("full_busy", 32'(busy), 0);

    // idle timeout closes a 2-word burst
    base = beat_q.size();
    push(8'hA1);
    push(8'hA2);
    n = 1;
    while (!m_tvalid && n < 100) begin tick(); n++; end
    check("tmo_latency", 32'(n), 32'(TO + 4));
    run(10);
    check("tmo_beats", 32'(beat_q.size() - base), 2);
    check_burst("tmo", base, 8'hA1, 2);
    check("tmo_empty", 32'(fifo_is_empty), 1);
    check("tmo_busy", 32'(busy), 0);

    // backpressure
    base = beat_q.size(); p0 = pops;
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    n = 0;
    while (!m_tvalid && n < 50) begin tick(); n++; end
    check("bp_valid", 32'(m_tvalid), 1);
    run(3);
    check("bp_pops_stalled", 32'(pops - p0), 2);
    for (int i = 0; i < 7; i++) begin
      m_tready = pat[i][0];
      tick();
    end
    m_tready = 1'b1;
    run(10);
    check("bp_beats", 32'(beat_q.size() - base), 4);
    check_burst("bp", base, 8'h30, 4);
    check("bp_pops", 32'(pops - p0), 4);
    check("bp_stall_stable", 32'(stall_err), 0);

    // flush closes a 3-word burst early
    base = beat_q.size();
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
    run(2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (!m_tvalid && n < 100) begin tick(); n++; end
    check("flush_latency", 32'(n), 3);
    run(10);
    check("flush_beats", 32'(beat_q.size() - base), 3);
    check_burst("flush", base, 8'h40, 3);
    check("flush_busy", 32'(busy), 0);

    // flush during READ queues a follow-up short burst
    base = beat_q.size();
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    n = 0;
    while (!fifo_r_en && n < 50) begin tick(); n++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(16);
    check("flush_rd_beats", 32'(beat_q.size() - base), 6);
    check_burst("flush_rd_a", base, 8'h50, 4);
    check_burst("flush_rd_b", base + 4, 8'h54, 2);

    // reset after beat 2 of 4
    base = beat_q.size();
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    n = 0;
    while (beat_q.size() - base < 2 && n < 60) begin tick(); n++; end
    check("mid_pre_valid", 32'(m_tvalid), 1);
    rst = 1'b1;
    #1;
    check("mid_tvalid", 32'(m_tvalid), 0);
    check("mid_r_en",   32'(fifo_r_en), 0);
    check("mid_busy",   32'(busy), 0);
    check("mid_tlast",  32'(m_tlast), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b1 = beat_q.size();
    run(30);
    check("mid_no_stale", 32'(beat_q.size() - b1), 0);
    check("mid_busy_after", 32'(busy), 0);

    // empty flag held high mid-burst
    base = beat_q.size(); p0 = pops;
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    n = 0;
    while (!fifo_r_en && n < 50) begin tick(); n++; end
    hold_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("starve_r_en%0d", i), 32'(fifo_r_en), 0);
      tick();
    end
    hold_empty = 1'b0;
    run(20);
    check("starve_beats", 32'(beat_q.size() - base), 4);
    check_burst("starve", base, 8'h70, 4);
    check("starve_pops", 32'(pops - p0), 4);

    check("pop_when_empty", 32'(empty_pop_err), 0);
    check("pops_ahead", 32'(ahead_err), 0);
    check("stall_stable_all", 32'(stall_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
